// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response bundle for the sequential ALU.
//   Request side : in_valid, in_ready, op[3:0], a[WIDTH-1:0], b[WIDTH-1:0]
//   Response side: out_valid, out_ready, r[WIDTH-1:0], f[3:0] = {N,Z,C,V}
// The master modport is the requester/consumer. The slave modport is the ALU.
interface alu_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] r;
  logic [3:0]       f;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, r, f
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, r, f
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with a valid/ready request and response handshake.
// ADD, SUB, logic ops and pass-through finish one cycle after accept.
// Shifts move one bit per cycle, and MUL is a shift-add that uses one
// multiplier bit per cycle.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   io    - alu_seq_if.slave (in_valid/in_ready/op/a/b, out_valid/out_ready/r/f)
// Flags f = {N,Z,C,V}.
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic       clk,
  input logic       rst_n,
  alu_seq_if.slave  io
);

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b0101;
  localparam logic [3:0] OP_XOR = 4'b0110;
  localparam logic [3:0] OP_SHR = 4'b0111;
  localparam logic [3:0] OP_SHL = 4'b1000;
  localparam logic [3:0] OP_MUL = 4'b1001;

  // The counter must reach WIDTH for MUL and any SHW-bit shift amount.
  localparam int CWL = $clog2(WIDTH + 1);
  localparam int CW  = (SHW > CWL) ? SHW : CWL;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nx;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] aux;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    term;
  logic [CW-1:0]    cnt_nx;
  logic [WIDTH-1:0] r_q;
  logic [3:0]       f_q;

  logic             accept;
  logic             multi;
  logic [SHW-1:0]   n;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] quick_r;
  logic             quick_c;
  logic             quick_v;

  logic [WIDTH-1:0] work_nx;
  logic [WIDTH-1:0] aux_nx;
  logic [WIDTH-1:0] acc_nx;
  logic             carry_nx;
  logic [WIDTH-1:0] fin_r;
  logic             fin_c;
  logic             last_iter;

  assign accept = io.in_valid && (state == IDLE);
  assign n      = io.b[SHW-1:0];
  // A zero-length shift is handled as a single-cycle operation.
  assign multi  = (io.op == OP_MUL) ||
                  (((io.op == OP_SHR) || (io.op == OP_SHL)) && (n != '0));

  // Single-cycle results use the live operands. These are the values captured at accept.
  always_comb begin
    sum     = {1'b0, io.a} + {1'b0, io.b};
    diff    = {1'b0, io.a} - {1'b0, io.b};
    quick_r = io.a;
    quick_c = 1'b0;
    quick_v = 1'b0;
    case (io.op)
      OP_ADD: begin
        quick_r = sum[WIDTH-1:0];
        quick_c = sum[WIDTH];
        quick_v = (io.a[WIDTH-1] == io.b[WIDTH-1]) &&
                  (sum[WIDTH-1] != io.a[WIDTH-1]);
      end
      OP_SUB: begin
        quick_r = diff[WIDTH-1:0];
        // The borrow out of the extended subtraction is exactly a < b unsigned.
        quick_c = diff[WIDTH];
        quick_v = (io.a[WIDTH-1] != io.b[WIDTH-1]) &&
                  (diff[WIDTH-1] != io.a[WIDTH-1]);
      end
      OP_AND:  quick_r = io.a & io.b;
      OP_OR:   quick_r = io.a | io.b;
      OP_XOR:  quick_r = io.a ^ io.b;
      default: quick_r = io.a;
    endcase
  end

  // One iteration of the multi-cycle datapath.
  // Shifts use work as the value register.
  // MUL uses work as the shifting multiplicand and aux as the multiplier.
  always_comb begin
    work_nx  = work;
    aux_nx   = aux;
    acc_nx   = acc;
    carry_nx = 1'b0;
    case (op_q)
      OP_SHR: begin
        work_nx  = work >> 1;
        carry_nx = work[0];
      end
      OP_SHL: begin
        work_nx  = work << 1;
        carry_nx = work[WIDTH-1];
      end
      default: begin
        if (aux[0]) acc_nx = acc + work;
        work_nx = work << 1;
        aux_nx  = aux >> 1;
      end
    endcase
    fin_r = (op_q == OP_MUL) ? acc_nx : work_nx;
    fin_c = (op_q == OP_MUL) ? 1'b0 : carry_nx;
  end

  assign cnt_nx    = cnt + CW'(1);
  assign last_iter = (cnt_nx == term);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = multi ? BUSY : DONE;
      BUSY:    if (last_iter) state_nx = DONE;
      DONE:    if (io.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign io.in_ready  = (state == IDLE);
  assign io.out_valid = (state == DONE);
  assign io.r         = r_q;
  assign io.f         = f_q;

  // The final iteration loads the result into r and f together with the move to DONE.
  // While in DONE, r and f are held until the consumer takes them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= '0;
      work <= '0;
      aux  <= '0;
      acc  <= '0;
      cnt  <= '0;
      term <= '0;
      r_q  <= '0;
      f_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q <= io.op;
            cnt  <= '0;
            if (multi) begin
              work <= io.a;
              aux  <= io.b;
              acc  <= '0;
              term <= (io.op == OP_MUL) ? CW'(WIDTH) : CW'(n);
            end else begin
              r_q <= quick_r;
              f_q <= {quick_r[WIDTH-1], (quick_r == '0), quick_c, quick_v};
            end
          end
        end
        BUSY: begin
          work <= work_nx;
          aux  <= aux_nx;
          acc  <= acc_nx;
          cnt  <= cnt_nx;
          if (last_iter) begin
            r_q <= fin_r;
            f_q <= {fin_r[WIDTH-1], (fin_r == '0), fin_c, 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and random checks of alu_seq (WIDTH=16).
// A reference model built from plain integer arithmetic gives the expected result, flags and latency.
module tb_alu_seq;

  localparam int W = 16;

  localparam logic [3:0] ADD = 4'b0001;
  localparam logic [3:0] SUB = 4'b0010;
  localparam logic [3:0] XOR = 4'b0110;
  localparam logic [3:0] SHR = 4'b0111;
  localparam logic [3:0] SHL = 4'b1000;
  localparam logic [3:0] MUL = 4'b1001;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;
  int   n_fail;

  alu_seq_if #(.WIDTH(W)) io();

  alu_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model. Flags come from the integer meaning of each operation.
  task automatic model(input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, output logic [W-1:0] r,
                       output logic [3:0] f, output int lat);
    int unsigned ua;
    int unsigned ub;
    int          sa;
    int          sb;
    int          s;
    int          n;
    logic [31:0] tmp;
    longint      prod;
    logic        c;
    logic        v;
    ua  = 32'(a);
    ub  = 32'(b);
    sa  = int'($signed(a));
    sb  = int'($signed(b));
    n   = int'(b[3:0]);
    c   = 1'b0;
    v   = 1'b0;
    lat = 1;
    case (op)
      ADD: begin
        tmp = ua + ub;
        r = tmp[W-1:0];
        c = (tmp >= 32'h10000);
        s = sa + sb;
        v = (s > 32767) || (s < -32768);
      end
      SUB: begin
        tmp = ua - ub;
        r = tmp[W-1:0];
        c = (ua < ub);
        s = sa - sb;
        v = (s > 32767) || (s < -32768);
      end
      4'b0100: r = a & b;
      4'b0101: r = a | b;
      XOR:     r = a ^ b;
      SHR: begin
        r = a >> n;
        if (n != 0) begin
          c = a[n-1];
          lat = n + 1;
        end
      end
      SHL: begin
        r = a << n;
        if (n != 0) begin
          c = a[W-n];
          lat = n + 1;
        end
      end
      MUL: begin
        prod = longint'(ua) * longint'(ub);
        r = prod[W-1:0];
        lat = W + 1;
      end
      default: r = a;
    endcase
    f = {r[W-1], (r == '0), c, v};
  endtask

  // Present a request and wait for the accept edge. Afterwards the operands are scrambled.
  task automatic startOp(input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b);
    @(negedge clk);
    io.op       = op;
    io.a        = a;
    io.b        = b;
    io.in_valid = 1'b1;
    io.out_ready = 1'b0;
    checkOutput("in_ready_idle", 32'(io.in_ready), 32'd1);
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
    io.op       = 4'($urandom);
    io.a        = W'($urandom);
    io.b        = W'($urandom);
  endtask

  // Run one operation to completion and check latency, result and flags.
  // The result is held under backpressure for a number of cycles before it is taken.
  task automatic applyStimulus(input string tag, input logic [3:0] op,
                               input logic [W-1:0] a, input logic [W-1:0] b,
                               input int hold);
    logic [W-1:0] er;
    logic [3:0]   ef;
    int           elat;
    int           lat;
    model(op, a, b, er, ef, elat);
    startOp(op, a, b);
    lat = 1;
    while (!io.out_valid && lat < 64) begin
      checkOutput({tag, "_in_ready_busy"}, 32'(io.in_ready), 32'd0);
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput({tag, "_latency"}, 32'(lat), 32'(elat));
    checkOutput({tag, "_r"}, 32'(io.r), 32'(er));
    checkOutput({tag, "_f"}, 32'(io.f), 32'(ef));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      io.in_valid = 1'b1;
      @(posedge clk);
      #1;
      checkOutput({tag, "_hold_valid"}, 32'(io.out_valid), 32'd1);
      checkOutput({tag, "_hold_r"}, 32'(io.r), 32'(er));
      checkOutput({tag, "_hold_f"}, 32'(io.f), 32'(ef));
      checkOutput({tag, "_hold_in_ready"}, 32'(io.in_ready), 32'd0);
    end
    @(negedge clk);
    io.in_valid  = 1'b1;
    io.out_ready = 1'b1;
    @(posedge clk);
    #1;
    io.in_valid  = 1'b0;
    io.out_ready = 1'b0;
    checkOutput({tag, "_done_valid"}, 32'(io.out_valid), 32'd0);
    checkOutput({tag, "_back_idle"}, 32'(io.in_ready), 32'd1);
  endtask

  initial begin
    n_checks     = 0;
    n_pass       = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    io.in_valid  = 1'b0;
    io.out_ready = 1'b0;
    io.op        = '0;
    io.a         = '0;
    io.b         = '0;

    #3;
    checkOutput("reset_out_valid", 32'(io.out_valid), 32'd0);
    checkOutput("reset_r", 32'(io.r), 32'd0);
    checkOutput("reset_f", 32'(io.f), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("reset_in_ready", 32'(io.in_ready), 32'd1);

    // Directed steps with known values.
    applyStimulus("add_ovf", ADD, 16'h7FFF, 16'h0001, 0);
    applyStimulus("sub_neg", SUB, 16'h0003, 16'h0005, 0);
    applyStimulus("sub_zero", SUB, 16'h1234, 16'h1234, 0);
    applyStimulus("add_carry", ADD, 16'hFFFF, 16'h0001, 0);
    applyStimulus("shl3", SHL, 16'h8001, 16'h0003, 0);
    applyStimulus("shr1", SHR, 16'h0001, 16'h0001, 0);
    applyStimulus("shl0", SHL, 16'hA5A5, 16'h0010, 0);
    applyStimulus("shr15", SHR, 16'h8000, 16'h000F, 1);
    applyStimulus("mul", MUL, 16'h0100, 16'h0101, 0);
    applyStimulus("mul_big", MUL, 16'hFFFF, 16'hFFFF, 0);
    applyStimulus("pass", 4'b1111, 16'hBEEF, 16'h1234, 0);
    applyStimulus("backpressure", ADD, 16'h8000, 16'h8000, 5);

    // Randomized operations, with random backpressure.
    for (int i = 0; i < 40; i++) begin
      applyStimulus("rand", 4'($urandom_range(0, 15)), W'($urandom),
                    W'($urandom), int'($urandom_range(0, 3)));
    end

    // Reset during a multiply. The earlier result is nonzero, so the r and f clear is visible.
    applyStimulus("pre_rst", ADD, 16'h8000, 16'h7FFF, 0);
    startOp(MUL, 16'h1234, 16'h5678);
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", 32'(io.out_valid), 32'd0);
    checkOutput("midrst_r", 32'(io.r), 32'd0);
    checkOutput("midrst_f", 32'(io.f), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("postrst_in_ready", 32'(io.in_ready), 32'd1);
    checkOutput("postrst_out_valid", 32'(io.out_valid), 32'd0);
    applyStimulus("xor_after_rst", XOR, 16'h00FF, 16'h0F0F, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 16, datapath width in bits (legal range 4..64).
REQ-002 Parameter SHW, default $clog2(WIDTH), width of the shift-amount field taken from b.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst_n  input  1  reset is asynchronous and active-low.
REQ-005 in_valid  input  1  operation request present.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 op  input  4  operation code, per REQ-013.
REQ-008 a  input  WIDTH  first operand.
REQ-009 b  input  WIDTH  second operand / shift amount.
REQ-010 out_valid  output  1  result and flags valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 r  output  WIDTH  result; f  output  4  flags {N,Z,C,V}, f[3]=N, f[2]=Z, f[1]=C, f[0]=V.

Function
REQ-013 Opcodes: 0001 ADD, 0010 SUB (a-b), 0100 AND, 0101 OR, 0110 XOR, 0111 SHR logical, 1000 SHL, 1001 MUL (low WIDTH bits, unsigned); all other codes pass a through.
REQ-014 FSM states IDLE, BUSY, DONE; in_ready SHALL be 1 only in IDLE.
REQ-015 Accept = in_valid && in_ready; op, a, b SHALL be captured at accept and be ignored thereafter until the next accept.
REQ-016 ADD/SUB/AND/OR/XOR/pass: IDLE -> DONE at accept; out_valid SHALL rise the cycle after accept (latency 1).
REQ-017 SHR/SHL: shift amount n = b[SHW-1:0]; n=0 behaves as single-cycle (REQ-016) with r=a, C=0; n>0 enters BUSY, shifting one bit per cycle, out_valid SHALL rise n+1 cycles after accept.
REQ-018 MUL: shift-add, one multiplier bit per cycle in BUSY; out_valid SHALL rise WIDTH+1 cycles after accept.
REQ-019 BUSY -> DONE when the iteration counter reaches its terminal count; counter width SHALL hold WIDTH.
REQ-020 DONE: r, f, out_valid SHALL hold stable while out_ready=0; DONE -> IDLE on out_ready=1, out_valid deasserting the next cycle.
REQ-021 out_valid and out_ready high in the same cycle SHALL complete exactly one transfer; no new accept in that cycle (in_ready=0).
REQ-022 N = r[WIDTH-1]; Z = (r == 0); both computed on the final result for every op.
REQ-023 C: ADD carry-out of bit WIDTH-1; SUB borrow (1 iff a < b unsigned); shifts last bit shifted out; 0 for logic, MUL, pass.
REQ-024 V: ADD 1 iff a,b same sign and r sign differs; SUB 1 iff a,b differ in sign and r sign differs from a; 0 for all other ops.
REQ-025 Sign/overflow tests SHALL use bit WIDTH-1 of the operands captured at accept, not live inputs.
REQ-026 MUL overflow above WIDTH bits SHALL be discarded silently.
REQ-027 Shift amounts >= WIDTH (possible only if SHW exceeds log2 WIDTH) SHALL yield r=0, C = last bit shifted out.

Reset
REQ-028 rst_n=0 SHALL immediately force state IDLE, out_valid=0, r=0, f=0, counter=0, irrespective of clk.
REQ-029 Reset asserted during BUSY or DONE SHALL abandon the operation with no result delivered; in_ready=1 the first rising edge after rst_n deasserts.

Verification
REQ-030 WIDTH=16: ADD a=0x7FFF b=0x0001, out_ready=1 -> one cycle later r=0x8000, f=1001 (N=1,Z=0,C=0,V=1).
REQ-031 SUB a=0x0003 b=0x0005 -> r=0xFFFE, f=1010 (N,C set); SUB a=b=0x1234 -> r=0, f=0100.
REQ-032 SHL a=0x8001 b=3 -> out_valid 4 cycles after accept, r=0x0008, C=0; SHR a=0x0001 b=1 -> r=0, f=0110.
REQ-033 MUL a=0x0100 b=0x0101 -> out_valid 17 cycles after accept, r=0x0100, f=0000; in_ready=0 throughout.
REQ-034 Backpressure: ADD completes with out_ready=0 for 5 cycles -> r, f, out_valid stable; out_ready=1 -> IDLE next cycle; in_valid held meanwhile not accepted.
REQ-035 Reset mid-MUL at cycle 8 -> out_valid, r, f zero immediately; after release, new XOR 0x00FF^0x0F0F accepted -> r=0x0FF0, f=0000.
